rx_frame_checker: RTL and testbench
===================================

RX_FRAME_CHECKER -- requirements
Module: rx_frame_checker

Interface
REQ-001 Parameter FRAME_LEN, default 4, number of F symbols in a good frame (legal range 1..14).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 CS  input  1  carrier sense from the channel.
REQ-005 data_in  input  2  symbol from the PLR: 0=Jam, 1=F, 2=ND, 3=illegal.
REQ-006 llc_ack  input  1  LLC acknowledge of a delivered frame.
REQ-007 send_plr  output  1  request to the PLR for the next symbol.
REQ-008 frame_ready  output  1  good frame held for the LLC.
REQ-009 frame_len  output  4  F-symbol count of the held frame.
REQ-010 len_err  output  1  one-cycle pulse: frame ended with a wrong F count.
REQ-011 jam_err  output  1  one-cycle pulse: Jam or illegal symbol received.
REQ-012 ovr_err  output  1  one-cycle pulse: good frame dropped because frame_ready was still high.
REQ-013 good_cnt  output  8  count of frames delivered to the LLC.

Function
REQ-014 send_plr SHALL equal the CS value registered on the previous clock edge.
REQ-015 A symbol SHALL be taken from data_in every cycle. Symbol code 3 SHALL be treated as Jam.
REQ-016 The FSM SHALL have three states: IDLE, RECV and DROP. It SHALL hold a 4-bit F counter, cnt.
REQ-017 IDLE: F -> RECV with cnt=1; Jam -> jam_err pulse, go to DROP; ND -> stay in IDLE.
REQ-018 RECV: F -> cnt+1, saturating at 15.
REQ-019 RECV: Jam -> jam_err pulse, go to DROP.
REQ-020 RECV: ND -> evaluate the frame (REQ-021 to REQ-023), then go to IDLE.
REQ-021 Evaluation with cnt==FRAME_LEN and slot free: frame_ready=1, frame_len=cnt, good_cnt+1.
REQ-022 Evaluation with cnt==FRAME_LEN and slot occupied: ovr_err pulse. frame_len and good_cnt SHALL be unchanged.
REQ-023 Evaluation with cnt!=FRAME_LEN (runt or long frame): len_err pulse. No delivery.
REQ-024 DROP: F and Jam SHALL be ignored; ND -> IDLE.
REQ-025 The slot is occupied when frame_ready=1 and llc_ack=0 in the same cycle.
REQ-026 frame_ready SHALL stay high until llc_ack is sampled high. It SHALL be low on the following cycle unless REQ-027 applies.
REQ-027 If llc_ack=1 and a good frame is evaluated in the same cycle, the new frame SHALL be delivered: frame_ready stays 1, frame_len updates, good_cnt increments, no ovr_err.
REQ-028 llc_ack while frame_ready=0 SHALL be ignored.
REQ-029 good_cnt SHALL wrap from 255 to 0.
REQ-030 The three error pulses SHALL be mutually exclusive and last exactly one cycle.
REQ-031 Latency: frame_ready SHALL rise on the clock edge that samples the terminating ND.
REQ-032 CS SHALL NOT influence the FSM; it drives send_plr only.

Reset
REQ-033 When reset=1 at a posedge:
- state=IDLE, cnt=0
- send_plr=0, frame_ready=0, frame_len=0
- len_err=0, jam_err=0, ovr_err=0, good_cnt=0
REQ-034 Reset SHALL take priority over all other inputs. A frame in progress during reset SHALL be discarded with no error pulse.

Verification
REQ-035 Scenario: the bench SHALL drive F,F,F,F,ND with FRAME_LEN=4 -> frame_ready=1 and frame_len=4 on the ND edge, good_cnt=1.
REQ-036 Scenario: the bench SHALL drive F,F,Jam,F,ND -> jam_err pulses on the Jam edge, no frame_ready, FSM in IDLE after ND.
REQ-037 Scenario: the bench SHALL drive F,F,ND and then F x5,ND -> len_err pulses twice, good_cnt stays 0.
REQ-038 Scenario: the bench SHALL deliver two good frames with llc_ack held 0 -> ovr_err pulses on the second ND, frame_len=4, good_cnt=1.
REQ-039 Scenario: the bench SHALL drive llc_ack=1 on the same cycle as the second frame's ND -> no ovr_err, frame_ready stays 1, good_cnt=2.
REQ-040 Scenario: the bench SHALL assert reset after F,F and then drive F,F,ND -> all outputs 0 after reset, then len_err pulses (cnt=2).

Source files
------------

// File: rtl/rx_frame_checker.sv
// rx_frame_checker: takes one PLR symbol per cycle, counts F symbols per
// frame and delivers frames of exactly FRAME_LEN symbols to the LLC.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | between frames, waiting for the first F
// RECV  | inside a frame, counting F symbols until ND or Jam
// DROP  | frame aborted by Jam/illegal, discarding symbols until ND
module rx_frame_checker #(
  parameter int FRAME_LEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CS,
  input  logic [1:0] data_in,
  input  logic       llc_ack,
  output logic       send_plr,
  output logic       frame_ready,
  output logic [3:0] frame_len,
  output logic       len_err,
  output logic       jam_err,
  output logic       ovr_err,
  output logic [7:0] good_cnt
);

  localparam logic [3:0] LP_FRAME_LEN = 4'(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_send_plr;
  logic       r_frame_ready;
  logic [3:0] r_frame_len;
  logic       r_len_err;
  logic       r_jam_err;
  logic       r_ovr_err;
  logic [7:0] r_good_cnt;

  logic w_sym_f;
  logic w_sym_nd;
  logic w_sym_jam;
  logic w_slot_busy;
  logic w_deliver;
  logic w_len_err;
  logic w_jam_err;
  logic w_ovr_err;

  // Code 3 is folded into Jam so an illegal symbol aborts the frame too.
  assign w_sym_f     = (data_in == 2'd1);
  assign w_sym_nd    = (data_in == 2'd2);
  assign w_sym_jam   = (data_in == 2'd0) || (data_in == 2'd3);
  // An ack in the same cycle frees the slot, so a back-to-back frame lands.
  assign w_slot_busy = r_frame_ready && !llc_ack;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_sym_f)        w_state_nxt = ST_RECV;
        else if (w_sym_jam) w_state_nxt = ST_DROP;
      end
      ST_RECV: begin
        if (w_sym_jam)     w_state_nxt = ST_DROP;
        else if (w_sym_nd) w_state_nxt = ST_IDLE;
      end
      ST_DROP: begin
        if (w_sym_nd) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: counter update, frame evaluation and error pulses
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_deliver = 1'b0;
    w_len_err = 1'b0;
    w_jam_err = 1'b0;
    w_ovr_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sym_f)        w_cnt_nxt = 4'd1;
        else if (w_sym_jam) w_jam_err = 1'b1;
      end
      ST_RECV: begin
        if (w_sym_f) begin
          if (r_cnt != 4'd15) w_cnt_nxt = r_cnt + 4'd1;
        end else if (w_sym_jam) begin
          w_jam_err = 1'b1;
        end else begin
          w_cnt_nxt = 4'd0;
          if (r_cnt != LP_FRAME_LEN) w_len_err = 1'b1;
          else if (w_slot_busy)      w_ovr_err = 1'b1;
          else                       w_deliver = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt         <= 4'd0;
      r_send_plr    <= 1'b0;
      r_frame_ready <= 1'b0;
      r_frame_len   <= 4'd0;
      r_len_err     <= 1'b0;
      r_jam_err     <= 1'b0;
      r_ovr_err     <= 1'b0;
      r_good_cnt    <= 8'd0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_send_plr <= CS;
      r_len_err  <= w_len_err;
      r_jam_err  <= w_jam_err;
      r_ovr_err  <= w_ovr_err;
      if (w_deliver) begin
        r_frame_ready <= 1'b1;
        r_frame_len   <= r_cnt;
        r_good_cnt    <= r_good_cnt + 8'd1;
      end else if (r_frame_ready && llc_ack) begin
        r_frame_ready <= 1'b0;
      end
    end
  end

  assign send_plr    = r_send_plr;
  assign frame_ready = r_frame_ready;
  assign frame_len   = r_frame_len;
  assign len_err     = r_len_err;
  assign jam_err     = r_jam_err;
  assign ovr_err     = r_ovr_err;
  assign good_cnt    = r_good_cnt;

endmodule

// File: tb/tb_rx_frame_checker.sv
// Scoreboard bench for rx_frame_checker: each driven cycle pushes the
// outputs expected after the next edge; a monitor pops and compares them.
module tb_rx_frame_checker;

  localparam int LEN = 4;
  localparam logic [1:0] S_JAM = 2'd0, S_F = 2'd1, S_ND = 2'd2, S_ILL = 2'd3;

  logic       clk = 1'b0;
  logic       reset;
  logic       CS;
  logic [1:0] data_in;
  logic       llc_ack;
  logic       send_plr;
  logic       frame_ready;
  logic [3:0] frame_len;
  logic       len_err;
  logic       jam_err;
  logic       ovr_err;
  logic [7:0] good_cnt;

  typedef struct packed {
    logic       send_plr;
    logic       frame_ready;
    logic [3:0] frame_len;
    logic       len_err;
    logic       jam_err;
    logic       ovr_err;
    logic [7:0] good_cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // reference model state: 0 idle, 1 receiving, 2 dropping
  int m_state = 0;
  int m_cnt = 0;
  int m_fr = 0;
  int m_len = 0;
  int m_good = 0;

  rx_frame_checker #(.FRAME_LEN(LEN)) dut (
    .clk(clk), .reset(reset), .CS(CS), .data_in(data_in), .llc_ack(llc_ack),
    .send_plr(send_plr), .frame_ready(frame_ready), .frame_len(frame_len),
    .len_err(len_err), .jam_err(jam_err), .ovr_err(ovr_err), .good_cnt(good_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one edge and queue what the DUT should show after it.
  task automatic model_step(input logic rst, input logic cs, input logic [1:0] sym,
                            input logic ack);
    exp_t e;
    int le = 0, je = 0, oe = 0, fr_old;
    if (rst) begin
      m_state = 0; m_cnt = 0; m_fr = 0; m_len = 0; m_good = 0;
      e = '0;
    end else begin
      fr_old = m_fr;
      if (fr_old == 1 && ack) m_fr = 0;
      if (m_state == 0) begin
        if (sym == S_F) begin m_state = 1; m_cnt = 1; end
        else if (sym != S_ND) begin je = 1; m_state = 2; end
      end else if (m_state == 1) begin
        if (sym == S_F) m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
        else if (sym != S_ND) begin je = 1; m_state = 2; end
        else begin
          if (m_cnt != LEN) le = 1;
          else if (fr_old == 1 && !ack) oe = 1;
          else begin m_fr = 1; m_len = m_cnt; m_good = (m_good + 1) % 256; end
          m_cnt = 0;
          m_state = 0;
        end
      end else if (sym == S_ND) begin
        m_state = 0;
      end
      e.send_plr    = cs;
      e.frame_ready = m_fr[0];
      e.frame_len   = m_len[3:0];
      e.len_err     = le[0];
      e.jam_err     = je[0];
      e.ovr_err     = oe[0];
      e.good_cnt    = m_good[7:0];
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic rst, input logic [1:0] sym, input logic ack);
    logic cs;
    @(negedge clk);
    cs = 1'($urandom_range(0, 1));
    reset = rst; CS = cs; data_in = sym; llc_ack = ack;
    model_step(rst, cs, sym, ack);
  endtask

  task automatic sym(input logic [1:0] s, input logic ack = 1'b0);
    drive(1'b0, s, ack);
  endtask

  task automatic frame(input int nf, input logic ack_on_nd);
    for (int i = 0; i < nf; i++) sym(S_F);
    sym(S_ND, ack_on_nd);
  endtask

  // Compare DUT outputs against the oldest queued expectation after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("send_plr",    int'(send_plr),    int'(e.send_plr));
      check("frame_ready", int'(frame_ready), int'(e.frame_ready));
      check("frame_len",   int'(frame_len),   int'(e.frame_len));
      check("len_err",     int'(len_err),     int'(e.len_err));
      check("jam_err",     int'(jam_err),     int'(e.jam_err));
      check("ovr_err",     int'(ovr_err),     int'(e.ovr_err));
      check("good_cnt",    int'(good_cnt),    int'(e.good_cnt));
    end
  end

  initial begin
    int wait_cyc;
    reset = 1'b1; CS = 1'b0; data_in = S_ND; llc_ack = 1'b0;
    drive(1'b1, S_F, 1'b1);
    drive(1'b1, S_F, 1'b0);

    // good frame, then release it
    frame(4, 1'b0);
    sym(S_ND, 1'b1);
    sym(S_ND, 1'b1);            // ack with nothing held is ignored

    // aborted frame, then illegal symbol while idle
    sym(S_F); sym(S_F); sym(S_JAM); sym(S_F); sym(S_ND);
    sym(S_ILL); sym(S_F); sym(S_ND);

    // runt and long frames
    frame(2, 1'b0);
    frame(5, 1'b0);

    // overrun: second good frame while the first is still held
    frame(4, 1'b0);
    frame(4, 1'b0);
    sym(S_ND); sym(S_ND);
    // ack coinciding with the next good frame's ND delivers it
    frame(4, 1'b1);
    sym(S_ND, 1'b1);

    // counter saturates and the frame is still rejected
    frame(17, 1'b0);
    // FRAME_LEN-1 / FRAME_LEN+1 boundaries
    frame(LEN - 1, 1'b0);
    frame(LEN + 1, 1'b0);

    // reset mid-frame discards it silently
    sym(S_F); sym(S_F);
    drive(1'b1, S_F, 1'b0);
    frame(2, 1'b0);

    // good_cnt wraps past 255
    for (int k = 0; k < 258; k++) frame(4, 1'b1);
    sym(S_ND, 1'b1);
    sym(S_ND);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
